// File: rtl/wb_arbiter_2m_if.sv
// =============================================================================
// Module  : wshb_if
// Brief   : Wishbone classic bus bundle (32-bit address/data) with master/slave views.
// Revision: 1.0
// =============================================================================
`default_nettype none

interface wshb_if;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dat_ms, sel, we, stb, cyc, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  adr, dat_ms, sel, we, stb, cyc, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

`default_nettype wire

// File: rtl/wb_arbiter_2m.sv
// =============================================================================
// Module  : wb_arbiter_2m
// Brief   : Two-master round-robin Wishbone classic arbiter onto one slave.
//           Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
// Revision: 1.0
// =============================================================================
`default_nettype none

module wb_arbiter_2m #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    wshb_if.slave     wb_m0,
    wshb_if.slave     wb_m1,
    wshb_if.master    wb_s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q;
    logic   last_grant_q;
    logic   w_req0;
    logic   w_req1;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_timeout;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 2..1023");
        end
    endgenerate

    assign w_req0 = wb_m0.cyc & wb_m0.stb;
    assign w_req1 = wb_m1.cyc & wb_m1.stb;
    assign w_gnt0 = (state_q == GNT0);
    assign w_gnt1 = (state_q == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [9:0] c_TO_LIMIT = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] wd_cnt_q;
    assign w_timeout = (state_q != IDLE) && (wd_cnt_q == c_TO_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    // Grant is only ever released through IDLE, so a new owner always sees one idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_req0 && (!w_req1 || last_grant_q)) begin
                        state_q <= GNT0;
                    end else if (w_req1) begin
                        state_q <= GNT1;
                    end
                end
                GNT0: begin
                    if (!wb_m0.cyc || w_timeout) begin
                        state_q      <= IDLE;
                        last_grant_q <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!wb_m1.cyc || w_timeout) begin
                        state_q      <= IDLE;
                        last_grant_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Held at zero in IDLE so every grant starts counting from a clean slate.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else if (state_q == IDLE || wb_s.ack) begin
            wd_cnt_q <= '0;
        end else if (wb_s.stb) begin
            wd_cnt_q <= wd_cnt_q + 10'd1;
        end
    end
`endif

    always_comb begin
        wb_s.adr    = '0;
        wb_s.dat_ms = '0;
        wb_s.sel    = '0;
        wb_s.we     = 1'b0;
        wb_s.cyc    = 1'b0;
        wb_s.stb    = 1'b0;
        wb_s.cti    = '0;
        wb_s.bte    = '0;
        case (state_q)
            GNT0: begin
                wb_s.adr    = wb_m0.adr;
                wb_s.dat_ms = wb_m0.dat_ms;
                wb_s.sel    = wb_m0.sel;
                wb_s.we     = wb_m0.we;
                wb_s.cyc    = wb_m0.cyc;
                wb_s.stb    = wb_m0.stb & ~w_timeout;
                wb_s.cti    = wb_m0.cti;
                wb_s.bte    = wb_m0.bte;
            end
            GNT1: begin
                wb_s.adr    = wb_m1.adr;
                wb_s.dat_ms = wb_m1.dat_ms;
                wb_s.sel    = wb_m1.sel;
                wb_s.we     = wb_m1.we;
                wb_s.cyc    = wb_m1.cyc;
                wb_s.stb    = wb_m1.stb & ~w_timeout;
                wb_s.cti    = wb_m1.cti;
                wb_s.bte    = wb_m1.bte;
            end
            default: ;
        endcase
    end

    // Responses while IDLE (late acks) reach neither master.
    assign wb_m0.ack    = w_gnt0 & wb_s.ack;
    assign wb_m0.err    = w_gnt0 & (wb_s.err | w_timeout);
    assign wb_m0.rty    = w_gnt0 & wb_s.rty;
    assign wb_m0.dat_sm = w_gnt0 ? wb_s.dat_sm : '0;

    assign wb_m1.ack    = w_gnt1 & wb_s.ack;
    assign wb_m1.err    = w_gnt1 & (wb_s.err | w_timeout);
    assign wb_m1.rty    = w_gnt1 & wb_s.rty;
    assign wb_m1.dat_sm = w_gnt1 ? wb_s.dat_sm : '0;

endmodule

`default_nettype wire
